// File: rtl/smi_stream_ctrl.sv
// SMI read-stream controller: NUM_CH FWFT FIFOs to the SMI bus, MSB-first bytes, zero-bubble prefetch.
// Optional per-channel underrun counters are built when SMI_STREAM_UNDERRUN_CNT_EN is defined.
module smi_stream_lane #(
    parameter int WORD_W = 32,
    parameter int SMI_W  = 8,
    parameter int BPW    = WORD_W / SMI_W,
    parameter int IDX_W  = (BPW > 1) ? $clog2(BPW) : 1
) (
    input  logic              i_sys_clk,
    input  logic              i_reset,
    input  logic [WORD_W-1:0] i_fifo_data,
    input  logic              i_fifo_empty,
    input  logic              i_consume,
    output logic              o_pull,
    output logic              o_valid,
    output logic [SMI_W-1:0]  o_byte,
    output logic              o_underrun
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(BPW - 1);

    logic [WORD_W-1:0] r_hold;
    logic              r_valid;
    logic [IDX_W-1:0]  r_idx;
    logic              w_last;

    assign w_last     = i_consume & r_valid & (r_idx == LAST);
    // Refilling on the last-byte consume keeps the byte stream gap-free across words.
    assign o_pull     = ~i_reset & ~i_fifo_empty & (~r_valid | w_last);
    assign o_underrun = i_consume & ~r_valid;
    assign o_valid    = r_valid;
    assign o_byte     = r_hold[WORD_W-1-int'(r_idx)*SMI_W -: SMI_W];

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            r_hold  <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
        end else if (o_pull) begin
            r_hold  <= i_fifo_data;
            r_valid <= 1'b1;
            r_idx   <= '0;
        end else if (i_consume && r_valid) begin
            if (r_idx == LAST) begin
                r_valid <= 1'b0;
                r_idx   <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end
endmodule

module smi_stream_ctrl #(
    parameter int NUM_CH = 2,
    parameter int WORD_W = 32,
    parameter int SMI_W  = 8
) (
    input  logic                     i_sys_clk,
    input  logic                     i_reset,
    input  logic [4:0]               i_ioc,
    input  logic [7:0]               i_data_in,
    output logic [7:0]               o_data_out,
    input  logic                     i_cs,
    input  logic                     i_fetch_cmd,
    input  logic                     i_load_cmd,
    output logic [NUM_CH-1:0]        o_fifo_pull,
    input  logic [NUM_CH*WORD_W-1:0] i_fifo_data,
    input  logic [NUM_CH-1:0]        i_fifo_empty,
    input  logic [NUM_CH-1:0]        i_fifo_full,
    input  logic [2:0]               i_smi_a,
    input  logic                     i_smi_soe_se,
    input  logic                     i_smi_swe_srw,
    output logic [SMI_W-1:0]         o_smi_data_out,
    output logic                     o_smi_read_req,
    output logic                     o_smi_writing
);
    localparam int BPW   = WORD_W / SMI_W;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    // [0],[1]: SOE synchroniser; [2]: previous synchronised value for edge detect.
    logic [2:0]                    r_soe_pipe;
    logic [2:0]                    r_a_s0, r_a_s1;
    logic                          w_rise, w_sel_ok;
    logic [NUM_CH-1:0]             w_cons, w_valid, w_urun;
    logic [NUM_CH-1:0][SMI_W-1:0]  w_byte;
    logic [SMI_W-1:0]              w_byte_sel;
    logic [7:0]                    w_status, w_cnt_rd, w_rd;
    logic                          w_rd_hit;
    logic                          w_unused;

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            r_soe_pipe <= 3'b111;
            r_a_s0     <= '0;
            r_a_s1     <= '0;
        end else begin
            r_soe_pipe <= {r_soe_pipe[1:0], i_smi_soe_se};
            r_a_s0     <= i_smi_a;
            r_a_s1     <= r_a_s0;
        end
    end

    assign w_rise   = r_soe_pipe[1] & ~r_soe_pipe[2];
    assign w_sel_ok = int'(r_a_s1) < NUM_CH;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        assign w_cons[k] = w_rise & w_sel_ok & (r_a_s1 == 3'(k));
        smi_stream_lane #(.WORD_W(WORD_W), .SMI_W(SMI_W), .BPW(BPW), .IDX_W(IDX_W)) u_lane (
            .i_sys_clk    (i_sys_clk),
            .i_reset      (i_reset),
            .i_fifo_data  (i_fifo_data[k*WORD_W +: WORD_W]),
            .i_fifo_empty (i_fifo_empty[k]),
            .i_consume    (w_cons[k]),
            .o_pull       (o_fifo_pull[k]),
            .o_valid      (w_valid[k]),
            .o_byte       (w_byte[k]),
            .o_underrun   (w_urun[k])
        );
    end

    always_comb begin
        w_byte_sel = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (w_sel_ok && r_a_s1 == 3'(k) && w_valid[k]) w_byte_sel = w_byte[k];
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) o_smi_data_out <= '0;
        else         o_smi_data_out <= w_byte_sel;
    end

    assign o_smi_read_req = |(w_valid | ~i_fifo_empty);
    assign o_smi_writing  = i_smi_a[2];

`ifdef SMI_STREAM_UNDERRUN_CNT_EN
    logic [NUM_CH-1:0][7:0] r_cnt;
    logic [1:0]             r_usel;
    logic                   w_load3;

    assign w_load3 = i_cs & i_load_cmd & (i_ioc == 5'd3);

    // A clear of a channel beats an underrun landing in the same cycle.
    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            r_cnt  <= '0;
            r_usel <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_load3 && i_data_in[7] && i_data_in[1:0] == 2'(k)) r_cnt[k] <= '0;
                else if (w_urun[k] && r_cnt[k] != 8'hFF)                 r_cnt[k] <= r_cnt[k] + 8'd1;
            end
            if (w_load3) r_usel <= i_data_in[1:0];
        end
    end

    always_comb begin
        w_cnt_rd = 8'h00;
        for (int k = 0; k < NUM_CH; k++)
            if (r_usel == 2'(k)) w_cnt_rd = r_cnt[k];
    end
`else
    assign w_cnt_rd = 8'h00;
`endif

    always_comb begin
        w_status = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_status[2*k]   = i_fifo_empty[k];
            w_status[2*k+1] = i_fifo_full[k];
        end
    end

    always_comb begin
        w_rd_hit = 1'b1;
        case (i_ioc)
            5'd0:    w_rd = 8'h02;
            5'd1:    w_rd = w_status;
            5'd2:    w_rd = 8'(w_valid);
            5'd3:    w_rd = w_cnt_rd;
            default: begin w_rd = 8'h00; w_rd_hit = 1'b0; end
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_reset)                          o_data_out <= 8'h00;
        else if (i_cs && i_fetch_cmd && w_rd_hit) o_data_out <= w_rd;
    end

    assign w_unused = ^{i_smi_swe_srw, i_load_cmd, i_data_in, w_urun};
endmodule

// File: tb/tb_smi_stream_ctrl.sv
// Directed + randomized bench for smi_stream_ctrl against a byte-queue reference model.
module tb_smi_stream_ctrl;
    localparam int NUM_CH = 2;
    localparam int WORD_W = 32;
    localparam int SMI_W  = 8;
    localparam int BPW    = WORD_W / SMI_W;

    logic                     i_sys_clk = 1'b0;
    logic                     i_reset = 1'b1;
    logic [4:0]               i_ioc = '0;
    logic [7:0]               i_data_in = '0;
    logic [7:0]               o_data_out;
    logic                     i_cs = 1'b0, i_fetch_cmd = 1'b0, i_load_cmd = 1'b0;
    logic [NUM_CH-1:0]        o_fifo_pull;
    logic [NUM_CH*WORD_W-1:0] i_fifo_data = '0;
    logic [NUM_CH-1:0]        i_fifo_empty = '1;
    logic [NUM_CH-1:0]        i_fifo_full = '0;
    logic [2:0]               i_smi_a = '0;
    logic                     i_smi_soe_se = 1'b1;
    logic                     i_smi_swe_srw = 1'b1;
    logic [SMI_W-1:0]         o_smi_data_out;
    logic                     o_smi_read_req, o_smi_writing;

    smi_stream_ctrl #(.NUM_CH(NUM_CH), .WORD_W(WORD_W), .SMI_W(SMI_W)) dut (
        .i_sys_clk(i_sys_clk), .i_reset(i_reset), .i_ioc(i_ioc), .i_data_in(i_data_in),
        .o_data_out(o_data_out), .i_cs(i_cs), .i_fetch_cmd(i_fetch_cmd), .i_load_cmd(i_load_cmd),
        .o_fifo_pull(o_fifo_pull), .i_fifo_data(i_fifo_data), .i_fifo_empty(i_fifo_empty),
        .i_fifo_full(i_fifo_full), .i_smi_a(i_smi_a), .i_smi_soe_se(i_smi_soe_se),
        .i_smi_swe_srw(i_smi_swe_srw), .o_smi_data_out(o_smi_data_out),
        .o_smi_read_req(o_smi_read_req), .o_smi_writing(o_smi_writing)
    );

    always #5 i_sys_clk = ~i_sys_clk;

    int checks = 0, errors = 0;

    // FIFO contents (words) and reference model: each channel is just the byte stream of
    // everything pushed and not yet read, plus underrun counters and the register read value.
    logic [31:0] fq [NUM_CH][$];
    logic [7:0]  bq [NUM_CH][$];
    int          pulls [NUM_CH];
    int          ucnt [NUM_CH];
    int          usel = 0;
    logic [7:0]  last_dout = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bench-side FWFT FIFOs: pull sampled mid-cycle, popped just after the edge.
    initial begin
        logic [NUM_CH-1:0] pl;
        for (int k = 0; k < NUM_CH; k++) pulls[k] = 0;
        forever begin
            @(negedge i_sys_clk);
            pl = o_fifo_pull;
            chk("pull_while_empty", {30'd0, pl & i_fifo_empty}, 32'd0);
            if (i_reset) chk("pull_in_reset", {30'd0, pl}, 32'd0);
            @(posedge i_sys_clk);
            #1;
            for (int k = 0; k < NUM_CH; k++) begin
                if (pl[k] && fq[k].size() > 0) begin
                    void'(fq[k].pop_front());
                    pulls[k]++;
                end
                i_fifo_empty[k] = (fq[k].size() == 0);
                i_fifo_data[k*WORD_W +: WORD_W] = (fq[k].size() > 0) ? fq[k][0] : 32'd0;
            end
        end
    end

    function automatic logic [7:0] exp_byte(input int a);
        if (a < NUM_CH && bq[a].size() > 0) return bq[a][0];
        return 8'h00;
    endfunction

    function automatic logic exp_req();
        for (int k = 0; k < NUM_CH; k++) if (bq[k].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] exp_reg(input int ioc);
        logic [7:0] v;
        v = 8'h00;
        case (ioc)
            0: v = 8'h02;
            1: for (int k = 0; k < NUM_CH; k++) begin
                   v[2*k]   = (fq[k].size() == 0);
                   v[2*k+1] = i_fifo_full[k];
               end
            2: for (int k = 0; k < NUM_CH; k++) v[k] = (bq[k].size() > 0);
`ifdef SMI_STREAM_UNDERRUN_CNT_EN
            3: v = (usel < NUM_CH) ? 8'(ucnt[usel]) : 8'h00;
`endif
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    task automatic push(input int ch, input logic [31:0] w);
        fq[ch].push_back(w);
        for (int b = 0; b < BPW; b++) bq[ch].push_back(w[31-8*b -: 8]);
        repeat (3) @(posedge i_sys_clk);
    endtask

    // One host read: SOE low 5 cycles (byte sampled at the end), high 5 cycles.
    task automatic smi_read(input logic [2:0] a, input bit watch, output logic [7:0] got);
        int ai;
        ai = int'(a);
        @(posedge i_sys_clk); #2;
        i_smi_a = a;
        i_smi_soe_se = 1'b0;
        repeat (4) @(posedge i_sys_clk);
        @(negedge i_sys_clk);
        got = o_smi_data_out;
        chk("smi_byte", {24'd0, got}, {24'd0, exp_byte(ai)});
        chk("smi_writing", {31'd0, o_smi_writing}, {31'd0, a[2]});
        chk("read_req", {31'd0, o_smi_read_req}, {31'd0, exp_req()});
        @(posedge i_sys_clk); #2;
        i_smi_soe_se = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge i_sys_clk);
            if (watch) chk("no_bubble", {31'd0, o_smi_data_out == 8'h00}, 32'd0);
            @(posedge i_sys_clk);
        end
        if (ai < NUM_CH) begin
            if (bq[ai].size() > 0) void'(bq[ai].pop_front());
            else if (ucnt[ai] < 255) ucnt[ai]++;
        end
    endtask

    task automatic reg_op(input int ioc, input logic [7:0] din, input bit fetch, input bit load);
        @(posedge i_sys_clk); #2;
        i_cs = 1'b1; i_ioc = 5'(ioc); i_data_in = din;
        i_fetch_cmd = fetch; i_load_cmd = load;
        if (fetch && ioc <= 3) last_dout = exp_reg(ioc);
`ifdef SMI_STREAM_UNDERRUN_CNT_EN
        if (load && ioc == 3) begin
            usel = int'(din[1:0]);
            if (din[7] && usel < NUM_CH) ucnt[usel] = 0;
        end
`endif
        @(posedge i_sys_clk); #2;
        i_cs = 1'b0; i_fetch_cmd = 1'b0; i_load_cmd = 1'b0;
        @(negedge i_sys_clk);
        if (fetch) chk($sformatf("reg_rd_ioc%0d", ioc), {24'd0, o_data_out}, {24'd0, last_dout});
    endtask

    task automatic do_reset(input int n);
        int r;
        @(posedge i_sys_clk); #2;
        i_reset = 1'b1;
        repeat (n) @(posedge i_sys_clk);
        @(negedge i_sys_clk);
        chk("rst_smi_data", {24'd0, o_smi_data_out}, 32'd0);
        chk("rst_data_out", {24'd0, o_data_out}, 32'd0);
        chk("rst_pull", {30'd0, o_fifo_pull}, 32'd0);
        @(posedge i_sys_clk); #2;
        i_reset = 1'b0;
        // The word sitting in the holding register is lost; FIFO words survive.
        for (int k = 0; k < NUM_CH; k++) begin
            if (bq[k].size() > 0) begin
                r = bq[k].size() % BPW;
                if (r == 0) r = BPW;
                repeat (r) void'(bq[k].pop_front());
            end
            ucnt[k] = 0;
        end
        usel = 0;
        last_dout = 8'h00;
        repeat (3) @(posedge i_sys_clk);
    endtask

    initial begin
        logic [7:0]  g0, g1, g2, g3, g4, g5, g6, g7;
        logic [7:0]  g;
        logic [31:0] w;
        int          p0, op, a, ch;

        for (int k = 0; k < NUM_CH; k++) ucnt[k] = 0;

        // Reset to idle
        repeat (3) @(posedge i_sys_clk);
        @(negedge i_sys_clk);
        chk("reset_smi_data", {24'd0, o_smi_data_out}, 32'd0);
        chk("reset_data_out", {24'd0, o_data_out}, 32'd0);
        chk("reset_read_req", {31'd0, o_smi_read_req}, 32'd0);
        chk("reset_pull", {30'd0, o_fifo_pull}, 32'd0);
        @(posedge i_sys_clk); #2;
        i_reset = 1'b0;
        repeat (2) @(posedge i_sys_clk);
        reg_op(0, 8'h00, 1, 0);
        chk("version", {24'd0, o_data_out}, 32'h02);

        // Single word, then an underrun
        p0 = pulls[0];
        push(0, 32'hA1B2C3D4);
        smi_read(3'd0, 0, g0); smi_read(3'd0, 0, g1);
        smi_read(3'd0, 0, g2); smi_read(3'd0, 0, g3);
        chk("single_word", {g0, g1, g2, g3}, 32'hA1B2C3D4);
        chk("single_pulls", pulls[0] - p0, 32'd1);
        smi_read(3'd0, 0, g4);
        chk("underrun_byte", {24'd0, g4}, 32'd0);
        reg_op(3, 8'h00, 1, 0);
`ifdef SMI_STREAM_UNDERRUN_CNT_EN
        chk("underrun_cnt", {24'd0, o_data_out}, 32'd1);
`else
        chk("underrun_cnt", {24'd0, o_data_out}, 32'd0);
`endif

        // Back-to-back words on ch1; the refill rides on the 4th consume
        p0 = pulls[1];
        push(1, 32'h11223344);
        push(1, 32'h55667788);
        smi_read(3'd1, 0, g0); smi_read(3'd1, 0, g1);
        smi_read(3'd1, 0, g2); smi_read(3'd1, 1, g3);
        smi_read(3'd1, 0, g4); smi_read(3'd1, 0, g5);
        smi_read(3'd1, 0, g6); smi_read(3'd1, 0, g7);
        chk("b2b_first", {g0, g1, g2, g3}, 32'h11223344);
        chk("b2b_second", {g4, g5, g6, g7}, 32'h55667788);
        chk("b2b_pulls", pulls[1] - p0, 32'd2);

        // Channel isolation plus an out-of-range address
        push(0, 32'hDEADBEEF);
        push(1, 32'h0BADF00D);
        smi_read(3'd0, 0, g); smi_read(3'd1, 0, g);
        smi_read(3'd5, 0, g);
        chk("addr5_zero", {24'd0, g}, 32'd0);
        smi_read(3'd0, 0, g); smi_read(3'd1, 0, g);
        smi_read(3'd1, 0, g); smi_read(3'd0, 0, g);
        chk("iso_ch0_3rd", {24'd0, g}, 32'h000000BE);
        reg_op(2, 8'h00, 1, 0);

        // Status bits
        i_fifo_full = 2'b10;
        while (bq[0].size() > 0) smi_read(3'd0, 0, g);
        push(1, 32'h01020304);
        push(1, 32'h05060708);
        reg_op(1, 8'h00, 1, 0);
        chk("status_09", {24'd0, o_data_out}, 32'h09);
        i_fifo_full = 2'b00;

        // Underrun saturation and clear (fetch+load returns the pre-load value)
        reg_op(3, 8'h00, 0, 1);
        for (int i = 0; i < 300; i++) smi_read(3'd0, 0, g);
        reg_op(3, 8'h00, 1, 0);
`ifdef SMI_STREAM_UNDERRUN_CNT_EN
        chk("sat_255", {24'd0, o_data_out}, 32'd255);
`endif
        reg_op(3, 8'h80, 1, 1);
        reg_op(3, 8'h00, 1, 0);
        chk("cleared", {24'd0, o_data_out}, 32'd0);

        // Reset mid-word
        while (bq[1].size() > 0) smi_read(3'd1, 0, g);
        push(0, 32'hCAFEBABE);
        push(0, 32'h12345678);
        smi_read(3'd0, 0, g); smi_read(3'd0, 0, g);
        do_reset(3);
        smi_read(3'd0, 0, g);
        chk("post_reset_msb", {24'd0, g}, 32'h12);

        // Randomized mix
        for (int i = 0; i < 200; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 2) begin
                ch = $urandom_range(0, NUM_CH - 1);
                w = $urandom;
                if (fq[ch].size() < 4) push(ch, w);
            end else if (op <= 6) begin
                a = $urandom_range(0, 9);
                if (a > 7) a = a - 8;
                smi_read(3'(a), 0, g);
            end else if (op == 7) begin
                i_fifo_full = 2'($urandom);
                reg_op($urandom_range(0, 7), 8'h00, 1, 0);
            end else begin
                reg_op($urandom_range(0, 4), 8'($urandom), $urandom_range(0, 1), 1);
            end
        end

        for (int k = 0; k < NUM_CH; k++) while (bq[k].size() > 0) smi_read(3'(k), 0, g);
        @(negedge i_sys_clk);
        chk("final_idle_req", {31'd0, o_smi_read_req}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/smi_stream_ctrl.md
# smi_stream_ctrl

Parametrised SMI read-stream controller feeding the Raspberry Pi SMI bus from `NUM_CH` sample FIFOs. It is the successor to the two-channel, fixed 32-bit SMI controller. It adds:
- generic channel count and word/bus widths
- a synchronised strobe path
- per-channel word holding registers with zero-bubble prefetch
- defined underrun behaviour

It sits between the per-channel RX FIFOs and the SMI pads, and answers the IOC register bus.

## Interface
Parameters:
- `NUM_CH`, 2, number of stream channels, 1..4; SMI address `a` selects channel `a` when `a < NUM_CH`.
- `WORD_W`, 32, FIFO word width; integer multiple of `SMI_W`.
- `SMI_W`, 8, SMI data bus width; `BPW = WORD_W/SMI_W` bytes per word.

Ports:
- `i_sys_clk` in 1: FPGA clock.
- `i_reset` in 1: synchronous, active-high reset, sampled on `i_sys_clk`.
- `i_ioc` in 5: register index.
- `i_data_in` in 8: register write data.
- `o_data_out` out 8: register read data.
- `i_cs` in 1: block select.
- `i_fetch_cmd` in 1: register read strobe.
- `i_load_cmd` in 1: register write strobe.
- `o_fifo_pull` out `NUM_CH`: pop, one bit per channel.
- `i_fifo_data` in `NUM_CH*WORD_W`: first-word-fall-through data; channel k is at `[k*WORD_W +: WORD_W]`.
- `i_fifo_empty` in `NUM_CH`: FIFO empty flags.
- `i_fifo_full` in `NUM_CH`: FIFO full flags.
- `i_smi_a` in 3: SMI address (asynchronous).
- `i_smi_soe_se` in 1: SMI read strobe, active-low (asynchronous).
- `i_smi_swe_srw` in 1: unused; reserved for the write path.
- `o_smi_data_out` out `SMI_W`: read data to the pads.
- `o_smi_read_req` out 1: data pending.
- `o_smi_writing` out 1: `i_smi_a[2]`, combinational.

## Operation
- **Strobe synchronisation**
  - `i_smi_soe_se` and `i_smi_a` pass through 2-flop synchronisers.
  - A rising edge of the synchronised SOE (end of a host read) with synchronised address `a < NUM_CH` is a "consume" for channel `a`.
  - Consumes for `a >= NUM_CH` are ignored.
- **Per-channel state**
  - `hold[k]`: `WORD_W` bits.
  - `valid[k]`: 1 bit.
  - `idx[k]`: `$clog2(BPW)` bits, or 1 bit if `BPW == 1`.
- **Byte order and index**
  - Presented byte is `hold[k][WORD_W-1-idx*SMI_W -: SMI_W]`, MSB first.
  - A consume with `valid=1` increments `idx`.
  - On a consume at `idx == BPW-1`, `idx` returns to 0 and `valid` clears.
- **Prefetch**
  - `o_fifo_pull[k]` is combinational and high for one cycle when `!i_fifo_empty[k]` and either:
    - `!valid[k]`, or
    - a consume of the last byte occurs this cycle.
  - In that same cycle: `hold <= i_fifo_data` slice, `valid <= 1`, `idx <= 0`.
  - A last-byte consume together with a pull produces no bubble.
  - The pull is never asserted while `i_fifo_empty[k]` is high.
- **Underrun**: a consume with `valid=0` leaves the channel state unchanged and is an underrun event.
- **SMI output**: `o_smi_data_out` is registered every cycle.
  - Selected channel valid: the presented byte of the selected channel.
  - Otherwise: all zeros.
- **Read request**: `o_smi_read_req` = OR over k of (`valid[k] | !i_fifo_empty[k]`).
- **Registers**: fetch loads `o_data_out` when `i_cs & i_fetch_cmd`; load acts when `i_cs & i_load_cmd`.
  - ioc 0: module version, `8'h02`.
  - ioc 1: bit 2k = `empty[k]`, bit 2k+1 = `full[k]`; bits for absent channels read 0.
  - ioc 2: bits[3:0] = `valid` mask; upper bits 0.
  - ioc 3: underrun counter of the selected channel (see Configuration).
  - Other ioc values: `o_data_out` holds its value.
- **Reset**:
  - `o_data_out = 0`, `o_smi_data_out = 0`.
  - Every `o_fifo_pull` bit low (no pull in the reset cycle).
  - `valid = 0`, `idx = 0`, `hold = 0`.
  - Synchronisers preset to SOE high, address 0.
  - Underrun counters 0, underrun select 0.
  - Reset mid-word discards the held words; FIFO contents are untouched.

## Timing
- Latency, SOE pin rising edge to consume: 3 cycles (2 sync + edge detect).
- Consume to the next byte on `o_smi_data_out`: 1 cycle.
- Host SOE low and high phases must each be at least 4 `i_sys_clk` cycles. `i_smi_a` must be stable from SOE falling to 3 cycles after SOE rising.
- Pull to `hold` valid: same clock edge.
- FIFO data to SMI pins: 1 cycle when the channel is already selected.
- Simultaneous consumes on different channels cannot occur (single address).
- Fetch and load in the same cycle: the load applies, and the fetch returns the pre-load value.

## Configuration
- Macro `SMI_STREAM_UNDERRUN_CNT_EN`.
- **Defined**:
  - Each channel has an 8-bit underrun counter that saturates at 255.
  - Load to ioc 3 with `i_data_in[1:0]` selects the channel.
  - `i_data_in[7]=1` also clears that channel's counter, in the same cycle.
  - If an underrun and a clear coincide, the clear wins.
  - Fetch of ioc 3 returns the counter of the selected channel.
- **Undefined**: no counters; ioc 3 reads `8'h00`; loads are ignored.

## Test plan
- **Reset to idle**: reset with FIFOs empty → all outputs 0, `o_smi_read_req=0`, ioc 0 reads `8'h02`.
- **Single word**: ch0 FIFO holds `32'hA1B2C3D4`, `a=0` → exactly one pull. Four SOE pulses read `A1, B2, C3, D4`. The fifth read returns `00`, and the ioc 3 count for ch0 is 1.
- **Back-to-back words**: ch1 holds `11223344`, `55667788`, `a=1`, 8 SOE pulses → bytes `11..88` in order. The second pull coincides with the 4th consume, with no `00` byte between words.
- **Channel isolation**: interleave reads `a=0`/`a=1` on distinct words → each channel's `idx` is preserved. A strobe at `a=5` changes nothing and outputs `00`.
- **Status and saturation**: force `full[1]=1`, `empty[0]=1` → ioc 1 reads `8'h09`. With the macro defined, 300 underruns on ch0 read 255; load `8'h80` reads 0.
- **Reset mid-word**: reset after 2 of 4 bytes → `valid` clears. After reset, the next FIFO word is pulled and its MSB byte is presented.
